// File: rtl/pi_digit_streamer_if.sv
// Handshake/data bundle between the pi accumulator, the digit streamer and the display logic.
interface pi_digit_streamer_if #(
    parameter int NINT  = 2,
    parameter int NFRAC = 48
);
    logic                  start;
    logic [NINT+NFRAC-1:0] value;
    logic [3:0]            digit;
    logic                  digit_point;
    logic                  digit_valid;
    logic                  digit_ready;
    logic [7:0]            SEG;
    logic                  busy;
    logic                  done;

    // Producer/consumer side (drives start, value, ready).
    modport master (
        output start, value, digit_ready,
        input  digit, digit_point, digit_valid, SEG, busy, done
    );

    // Streamer side.
    modport slave (
        input  start, value, digit_ready,
        output digit, digit_point, digit_valid, SEG, busy, done
    );
endinterface

// File: rtl/pi_digit_streamer.sv
// Latches a Q(NINT).(NFRAC) value on start and streams it as decimal digits
// (integer digit first, then NDIGITS truncated fractional digits) over a
// valid/ready handshake, mirroring each accepted digit on a 7-segment code.
module pi_digit_streamer #(
    parameter int NINT    = 2,
    parameter int NFRAC   = 48,
    parameter int NDIGITS = 12
) (
    input  logic               clk_2,
    input  logic               reset,
    pi_digit_streamer_if.slave bus
);
    localparam int CNT_W = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t             state_q, state_d;
    logic [NFRAC-1:0]   frac_q, frac_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         digit_q, digit_d;
    logic               dp_q, dp_d;
    logic               valid_q, valid_d;
    logic [7:0]         seg_q, seg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NINT+3:0]    int_ext;
    logic [NFRAC+3:0]   frac_x10;

    // Active-high 7-segment pattern (gfedcba) for a BCD digit.
    function automatic logic [6:0] segcode(input logic [3:0] d);
        case (d)
            4'd0:    segcode = 7'h3F;
            4'd1:    segcode = 7'h06;
            4'd2:    segcode = 7'h5B;
            4'd3:    segcode = 7'h4F;
            4'd4:    segcode = 7'h66;
            4'd5:    segcode = 7'h6D;
            4'd6:    segcode = 7'h7D;
            4'd7:    segcode = 7'h07;
            4'd8:    segcode = 7'h7F;
            4'd9:    segcode = 7'h6F;
            default: segcode = 7'h00;
        endcase
    endfunction

    // Integer part widened so the clamp-to-9 compare works for any NINT.
    assign int_ext  = {4'b0, bus.value[NINT+NFRAC-1:NFRAC]};
    // frac*10 as shift-add; the 4 extra bits hold the next digit exactly.
    assign frac_x10 = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);

    // State and output registers; reset clears everything and drops any stream.
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            frac_q  <= '0;
            cnt_q   <= '0;
            digit_q <= '0;
            dp_q    <= 1'b0;
            valid_q <= 1'b0;
            seg_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frac_q  <= frac_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: launch on start, advance one digit per transfer.
    always_comb begin
        state_d = state_q;
        frac_d  = frac_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        seg_d   = seg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    frac_d  = bus.value[NFRAC-1:0];
                    cnt_d   = '0;
                    digit_d = (int_ext > (NINT+4)'(9)) ? 4'd9 : int_ext[3:0];
                    dp_d    = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (valid_q && bus.digit_ready) begin
                    seg_d = {dp_q, segcode(digit_q)};
                    if (cnt_q == CNT_W'(NDIGITS)) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        digit_d = frac_x10[NFRAC+3:NFRAC];
                        frac_d  = frac_x10[NFRAC-1:0];
                        cnt_d   = cnt_q + 1'b1;
                        dp_d    = 1'b0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.digit       = digit_q;
    assign bus.digit_point = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.SEG         = seg_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_pi_digit_streamer.sv
// Randomized self-checking bench for pi_digit_streamer against a decimal
// expansion model (frac*10, take integer part, keep remainder).
module tb_pi_digit_streamer;
    localparam int NINT = 2, NFRAC = 48, NDIG = 12;
    localparam logic [49:0] PI_Q = 50'd884279719003555;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pi_digit_streamer_if #(.NINT(NINT), .NFRAC(NFRAC)) bus ();

    pi_digit_streamer #(.NINT(NINT), .NFRAC(NFRAC), .NDIGITS(NDIG)) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    function automatic logic [49:0] rand50();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        bus.start = 1'b0; bus.value = '0; bus.digit_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk_2);
        checks++;
        if ({bus.digit, bus.digit_point, bus.digit_valid, bus.SEG, bus.busy, bus.done} !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: got digit=%0d dp=%b vld=%b seg=%h busy=%b done=%b, want all 0",
                     bus.digit, bus.digit_point, bus.digit_valid, bus.SEG, bus.busy, bus.done);
        end
        reset = 1'b0;
        @(negedge clk_2);
    endtask

    // Streams value v. mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_stream(input logic [49:0] v, input int mode, input bit inj_start,
                              input bit start_at_done, input string nm);
        int         exp_d[$];
        logic [63:0] frac, p;
        int         idx, cyc;
        bit         pend, r;
        logic [7:0] pend_seg;
        exp_d.delete();
        exp_d.push_back((v[49:48] > 9) ? 9 : int'(v[49:48]));
        frac = {16'b0, v[47:0]};
        for (int k = 0; k < NDIG; k++) begin
            p = frac * 10;
            exp_d.push_back(int'(p >> 48));
            frac = p & ((64'd1 << 48) - 1);
        end
        @(negedge clk_2);
        bus.start = 1'b1; bus.value = v; bus.digit_ready = 1'b0;
        @(negedge clk_2);
        bus.start = 1'b0; bus.value = rand50();
        idx = 0; cyc = 0; pend = 0; pend_seg = '0;
        while (idx <= NDIG && cyc < 400) begin
            cyc++;
            if (pend) begin
                checks++;
                if (bus.SEG !== pend_seg) begin
                    errors++;
                    $display("FAIL %s seg[%0d]: got %h want %h", nm, idx - 1, bus.SEG, pend_seg);
                end
                pend = 0;
            end
            checks++;
            if (bus.digit_valid !== 1'b1 || bus.busy !== 1'b1 || bus.digit !== 4'(exp_d[idx]) ||
                bus.digit_point !== (idx == 0)) begin
                errors++;
                $display("FAIL %s digit[%0d] cyc %0d: got d=%0d dp=%b vld=%b busy=%b want d=%0d dp=%b vld=1 busy=1",
                         nm, idx, cyc, bus.digit, bus.digit_point, bus.digit_valid, bus.busy,
                         exp_d[idx], idx == 0);
            end
            if (inj_start && cyc == 3) begin
                bus.start = 1'b1; bus.value = ~v;
            end else bus.start = 1'b0;
            case (mode)
                0:       r = 1'b1;
                1:       r = ((cyc - 1) % 3 == 0);
                default: r = $urandom_range(0, 1) == 1;
            endcase
            bus.digit_ready = r;
            if (r) begin
                pend = 1;
                pend_seg = {idx == 0, SEG_TAB[exp_d[idx]]};
                idx++;
            end
            @(negedge clk_2);
        end
        bus.digit_ready = 1'b0; bus.start = 1'b0;
        checks++;
        if (idx <= NDIG) begin
            errors++;
            $display("FAIL %s timeout: got %0d digits want %0d", nm, idx, NDIG + 1);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.digit_valid !== 1'b0 || bus.busy !== 1'b0 || bus.SEG !== pend_seg) begin
            errors++;
            $display("FAIL %s done_cycle: got done=%b vld=%b busy=%b seg=%h want 1 0 0 %h",
                     nm, bus.done, bus.digit_valid, bus.busy, bus.SEG, pend_seg);
        end
        if (mode == 0) begin
            checks++;
            if (cyc + 1 != NDIG + 2) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", nm, cyc + 1, NDIG + 2);
            end
        end
        if (start_at_done) begin
            bus.start = 1'b1; bus.value = v;
        end
        @(negedge clk_2);
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.digit_valid !== 1'b0 || bus.busy !== 1'b0 || bus.SEG !== pend_seg) begin
            errors++;
            $display("FAIL %s idle_after: got done=%b vld=%b busy=%b seg=%h want 0 0 0 %h",
                     nm, bus.done, bus.digit_valid, bus.busy, bus.SEG, pend_seg);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk_2);
        bus.start = 1'b1; bus.value = PI_Q; bus.digit_ready = 1'b1;
        @(negedge clk_2);
        bus.start = 1'b0;
        repeat (5) @(negedge clk_2);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.digit, bus.digit_point, bus.digit_valid, bus.SEG, bus.busy, bus.done} !== 16'h0) begin
            errors++;
            $display("FAIL midstream_reset: got digit=%0d dp=%b vld=%b seg=%h busy=%b done=%b, want all 0",
                     bus.digit, bus.digit_point, bus.digit_valid, bus.SEG, bus.busy, bus.done);
        end
        @(negedge clk_2);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2);
            checks++;
            if (bus.done !== 1'b0 || bus.digit_valid !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: got done=%b vld=%b busy=%b want 0 0 0",
                         i, bus.done, bus.digit_valid, bus.busy);
            end
        end
        bus.digit_ready = 1'b0;
        run_stream(PI_Q, 0, 0, 0, "restart_pi");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) run_stream(rand50(), 2, 0, 0, "random");
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        run_stream((50'd3 << 48) + (50'd1 << 47), 0, 0, 0, "three_half");
        run_stream((50'd1 << 48) - 1, 0, 0, 0, "all_nines");
        run_stream(50'd1 << 46, 1, 0, 0, "quarter_stall");
        run_stream(PI_Q, 0, 0, 1, "pi_start_at_done");
        run_stream(PI_Q, 2, 1, 0, "pi_start_in_send");
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
